master_route_ctrl: RTL
======================

Name: master_route_ctrl

Overview:
- Registered, parametrised successor to the combinational master-to-slave mux.
- Routes the 8 serial control/data signals of one of NUM_MASTERS masters to one of NUM_SLAVES slaves.
- Latches the route on grant and holds it locked until the owning master signals tx_done or an inactivity timeout fires.
- Sits between the bus arbiter / address decoder and the slave ports; tx_done is forwarded to every slave.

Parameters:
- NUM_MASTERS, 2, number of master ports (≥1).
- NUM_SLAVES, 3, number of slave ports (≥1).
- TIMEOUT, 64, cycles of selected-master inactivity before forced release (≥2).
- SLV_IDX_W, $clog2(NUM_SLAVES+1), width of the 1-based slave index (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- bus_grant  in  NUM_MASTERS  one-hot master grant from arbiter; all-zero means none.
- slave_grant  in  SLV_IDX_W+1  bit0 = valid, [SLV_IDX_W:1] = 1-based slave number (3'b011 = slave 1, 3'b101 = slave 2, 3'b111 = slave 3).
- m_master_ready, m_master_valid, m_read_en, m_write_en, m_tx_address, m_tx_data, m_tx_burst, m_tx_done  in  NUM_MASTERS each  per-master serial signals; bit i belongs to master i.
- s_master_ready, s_master_valid, s_read_en, s_write_en, s_tx_address, s_tx_data, s_tx_burst, s_tx_done  out  NUM_SLAVES each  per-slave registered signals; bit j belongs to slave j+1.
- route_busy  out  1  high while a route is locked (ACTIVE).
- route_master  out  $clog2(NUM_MASTERS) (min 1)  latched master index; valid while route_busy.
- route_slave  out  SLV_IDX_W  latched 1-based slave number; valid while route_busy.
- grant_err  out  1  one-cycle pulse on a malformed grant.
- timeout_err  out  1  one-cycle pulse on inactivity abort.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE, every output 0, timeout counter 0. Reset mid-transaction drops the route immediately; no tx_done is forwarded.
- States: IDLE, ACTIVE, RELEASE.
- IDLE:
  - Grant is legal when bus_grant is exactly one-hot, slave_grant[0]=1, and 1 ≤ slave number ≤ NUM_SLAVES.
  - Legal grant: latch master index and slave number, go to ACTIVE next cycle.
  - Illegal grant: bus_grant multi-hot, or slave_grant[0]=1 with slave number 0 or >NUM_SLAVES. Pulse grant_err next cycle and stay in IDLE.
  - No grant (bus_grant=0 or slave_grant[0]=0): stay in IDLE, no error.
  - All s_* outputs are 0.
- ACTIVE:
  - Each cycle, all 8 signals of the latched master are registered onto bit (slave-1) of the s_* buses; every other slave bit is 0.
  - Latency is exactly 1 cycle, input at edge t → output after edge t+1.
  - bus_grant and slave_grant are ignored (route locked).
  - route_busy=1.
- Release on tx_done: when the latched master's m_tx_done=1, that cycle's signals, including s_tx_done=1, are still forwarded. Go to RELEASE.
- Timeout counter:
  - Clears when the latched master has m_master_valid=1 or m_tx_done=1; otherwise increments.
  - When the counter reaches TIMEOUT-1 with the master still inactive: pulse timeout_err, force all s_* to 0 next cycle, go to RELEASE.
  - If tx_done and timeout occur in the same cycle, tx_done wins and no timeout_err is raised.
- RELEASE: one cycle; all s_* = 0, route_busy=0, counter cleared; return to IDLE. New grants are first evaluated in IDLE, so the minimum gap between routes is 2 idle cycles on the slave side.
- route_master / route_slave hold their last values after release but are meaningful only while route_busy=1.
- No combinational path from any input to any output.

Decomposition:
- Shared package bus_pkg holds:
  - state enum {IDLE, ACTIVE, RELEASE};
  - the slave_grant field positions (valid bit 0, index bits above);
  - a function that checks one-hot and converts it to an index.
- One sub-module: route_timeout_ctr (TIMEOUT-parametrised counter with clear/inc/expire), instantiated once.

Test Plan:
- Legal route, master 1 to slave 2: bus_grant=2'b01, slave_grant=3'b101; drive m_tx_data pattern 1,0,1,1 then m_tx_done=1. Expect route_busy=1 from cycle 1; s_tx_data[1] reproduces the pattern 1 cycle delayed, s_tx_done[1]=1 on the final beat; slaves 1 and 3 stay 0; IDLE 2 cycles later.
- Route lock: during a master 2 → slave 3 route, change bus_grant to 2'b01 and slave_grant to 3'b011. Expect outputs unchanged, route_master=1, route_slave=3, until tx_done.
- Malformed grant: bus_grant=2'b11 with slave_grant=3'b011, then bus_grant=2'b01 with slave_grant=3'b001. Expect grant_err pulse 1 cycle after each, route_busy stays 0, all s_* stay 0.
- Timeout, TIMEOUT=4: route master 1 to slave 1, hold m_master_valid=0. Expect timeout_err pulse after 4 inactive cycles, s_* = 0, route_busy=0. In a second run, assert tx_done on the expiry cycle: no timeout_err, s_tx_done[0]=1.
- Reset mid-route: assert rst during ACTIVE. Expect all outputs 0 at the next edge, no s_tx_done, and a fresh grant accepted after rst deasserts.
- Parametrisation: NUM_MASTERS=4, NUM_SLAVES=5 (slave_grant 4 bits). Route master 3 to slave 5 with slave_grant=4'b1011. Expect only bit 4 of the s_* buses active; slave_grant=4'b1101 (slave 6) raises grant_err.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared types and helpers for the master-to-slave route controller.
// Holds FSM states, slave_grant field positions, signal slots and a one-hot decoder.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // slave_grant layout: valid flag in bit 0, 1-based slave number above it
  localparam int SG_VLD     = 0;
  localparam int SG_IDX_LSB = 1;

  // slot of each routed serial signal inside the 8-bit bundle
  localparam int SIG_N     = 8;
  localparam int SIG_RDY   = 0;
  localparam int SIG_VLD   = 1;
  localparam int SIG_RD    = 2;
  localparam int SIG_WR    = 3;
  localparam int SIG_ADDR  = 4;
  localparam int SIG_DATA  = 5;
  localparam int SIG_BURST = 6;
  localparam int SIG_DONE  = 7;

  // one-hot decoder: index of the single set bit, or a negative code
  localparam int OH_W     = 32;
  localparam int OH_NONE  = -1;
  localparam int OH_MULTI = -2;

  function automatic int oh_to_idx(input logic [OH_W-1:0] v);
    int idx;
    idx = OH_NONE;
    for (int i = 0; i < OH_W; i++) begin
      if (v[i]) idx = (idx == OH_NONE) ? i : OH_MULTI;
    end
    return idx;
  endfunction

endpackage

// File: rtl/route_timeout_ctr.sv
// route_timeout_ctr: inactivity counter for a locked route.
// Ports: clk, rst, clr_i (clear), inc_i (count one idle cycle), expire_o (last idle cycle).
module route_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // fires on the TIMEOUT-th consecutive idle cycle
  assign expire_o = inc_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/master_route_ctrl.sv
// master_route_ctrl: registered master-to-slave router with route locking.
// Ports: grants in, 8 per-master serial signals in, 8 per-slave signals out, route status/errors out.
module master_route_ctrl
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int TIMEOUT     = 64,
  parameter int SLV_IDX_W   = $clog2(NUM_SLAVES + 1),
  localparam int MW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] bus_grant,
  input  logic [SLV_IDX_W:0]     slave_grant,
  input  logic [NUM_MASTERS-1:0] m_master_ready,
  input  logic [NUM_MASTERS-1:0] m_master_valid,
  input  logic [NUM_MASTERS-1:0] m_read_en,
  input  logic [NUM_MASTERS-1:0] m_write_en,
  input  logic [NUM_MASTERS-1:0] m_tx_address,
  input  logic [NUM_MASTERS-1:0] m_tx_data,
  input  logic [NUM_MASTERS-1:0] m_tx_burst,
  input  logic [NUM_MASTERS-1:0] m_tx_done,
  output logic [NUM_SLAVES-1:0]  s_master_ready,
  output logic [NUM_SLAVES-1:0]  s_master_valid,
  output logic [NUM_SLAVES-1:0]  s_read_en,
  output logic [NUM_SLAVES-1:0]  s_write_en,
  output logic [NUM_SLAVES-1:0]  s_tx_address,
  output logic [NUM_SLAVES-1:0]  s_tx_data,
  output logic [NUM_SLAVES-1:0]  s_tx_burst,
  output logic [NUM_SLAVES-1:0]  s_tx_done,
  output logic                   route_busy,
  output logic [MW-1:0]          route_master,
  output logic [SLV_IDX_W-1:0]   route_slave,
  output logic                   grant_err,
  output logic                   timeout_err
);

  localparam logic [SLV_IDX_W-1:0] NS_MAX = SLV_IDX_W'(NUM_SLAVES);

  state_e                state_q, state_d;
  logic [MW-1:0]         mst_q, mst_d;
  logic [SLV_IDX_W-1:0]  slv_q, slv_d;
  logic                  busy_q, busy_d;
  logic                  gerr_q, gerr_d;
  logic                  terr_q, terr_d;
  logic [NUM_SLAVES-1:0] s_q [SIG_N];
  logic [NUM_SLAVES-1:0] s_d [SIG_N];

  int                    gidx;
  logic                  sg_vld;
  logic [SLV_IDX_W-1:0]  sg_num;
  logic                  sg_ok;
  logic [SIG_N-1:0]      sel_sig;
  logic                  fwd;
  logic                  tmo_clr;
  logic                  tmo_inc;
  logic                  tmo_exp;

  assign gidx   = oh_to_idx(OH_W'(bus_grant));
  assign sg_vld = slave_grant[SG_VLD];
  assign sg_num = slave_grant[SLV_IDX_W:SG_IDX_LSB];
  assign sg_ok  = (sg_num != '0) && (sg_num <= NS_MAX);

  // bundle of the locked master's eight serial signals
  assign sel_sig = {
    m_tx_done[mst_q],
    m_tx_burst[mst_q],
    m_tx_data[mst_q],
    m_tx_address[mst_q],
    m_write_en[mst_q],
    m_read_en[mst_q],
    m_master_valid[mst_q],
    m_master_ready[mst_q]
  };

  route_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmo_clr),
    .inc_i    (tmo_inc),
    .expire_o (tmo_exp)
  );

  always_comb begin
    state_d = state_q;
    mst_d   = mst_q;
    slv_d   = slv_q;
    busy_d  = 1'b0;
    gerr_d  = 1'b0;
    terr_d  = 1'b0;
    fwd     = 1'b0;
    tmo_clr = 1'b1;
    tmo_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gidx == OH_MULTI) begin
          gerr_d = 1'b1;
        end else if (gidx >= 0 && sg_vld) begin
          if (sg_ok) begin
            state_d = ACTIVE;
            mst_d   = MW'(gidx);
            slv_d   = sg_num;
            busy_d  = 1'b1;
          end else begin
            gerr_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        tmo_clr = sel_sig[SIG_VLD] | sel_sig[SIG_DONE];
        tmo_inc = ~tmo_clr;
        // done outranks expiry: expiry already requires done low
        if (sel_sig[SIG_DONE]) begin
          fwd     = 1'b1;
          state_d = RELEASE;
        end else if (tmo_exp) begin
          terr_d  = 1'b1;
          state_d = RELEASE;
        end else begin
          fwd    = 1'b1;
          busy_d = 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    s_d = '{default: '0};
    for (int k = 0; k < SIG_N; k++) begin
      for (int j = 0; j < NUM_SLAVES; j++) begin
        s_d[k][j] = fwd & sel_sig[k] & (slv_q == SLV_IDX_W'(j + 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mst_q   <= '0;
      slv_q   <= '0;
      busy_q  <= 1'b0;
      gerr_q  <= 1'b0;
      terr_q  <= 1'b0;
      s_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      mst_q   <= mst_d;
      slv_q   <= slv_d;
      busy_q  <= busy_d;
      gerr_q  <= gerr_d;
      terr_q  <= terr_d;
      s_q     <= s_d;
    end
  end

  assign s_master_ready = s_q[SIG_RDY];
  assign s_master_valid = s_q[SIG_VLD];
  assign s_read_en      = s_q[SIG_RD];
  assign s_write_en     = s_q[SIG_WR];
  assign s_tx_address   = s_q[SIG_ADDR];
  assign s_tx_data      = s_q[SIG_DATA];
  assign s_tx_burst     = s_q[SIG_BURST];
  assign s_tx_done      = s_q[SIG_DONE];
  assign route_busy     = busy_q;
  assign route_master   = mst_q;
  assign route_slave    = slv_q;
  assign grant_err      = gerr_q;
  assign timeout_err    = terr_q;

endmodule
